// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse press classifier.
// Latency: n/a (definitions only). Backpressure: n/a.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int DEF_CLK_FREQ      = 100_000;
    localparam int DEF_DOT_MAX_MS    = 200;
    localparam int DEF_LETTER_GAP_MS = 600;
    localparam int DEF_WORD_GAP_MS   = 1400;
    localparam int DEF_MAX_SYMBOLS   = 5;

    localparam int MS_W = 16;

    function automatic logic [MS_W-1:0] sat_inc(input logic [MS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-clock tick every CLK_FREQ/1000 clocks, restartable by clr.
// Latency: tick is a decode of the count register. Backpressure: none.
module ms_tick_gen #(
    parameter int CLK_FREQ = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_press_classifier.sv
// Times debounced presses/gaps in ms, classifies dot/dash and groups symbols into letters.
// Latency: symbol, letter and word events are registered one clock after their deciding cycle. No backpressure.
module morse_press_classifier
    import morse_pkg::*;
#(
    parameter int CLK_FREQ      = DEF_CLK_FREQ,
    parameter int DOT_MAX_MS    = DEF_DOT_MAX_MS,
    parameter int LETTER_GAP_MS = DEF_LETTER_GAP_MS,
    parameter int WORD_GAP_MS   = DEF_WORD_GAP_MS,
    parameter int MAX_SYMBOLS   = DEF_MAX_SYMBOLS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_in,
    output logic                   sym_valid,
    output logic                   sym_is_dash,
    output logic                   letter_valid,
    output logic [MAX_SYMBOLS-1:0] letter_code,
    output logic [2:0]             letter_len,
    output logic                   letter_err,
    output logic                   word_gap,
    output logic                   busy
);

    state_t                 r_state;
    logic                   r_btn_d;
    logic                   r_armed;
    logic [MS_W-1:0]        r_ms_cnt;
    logic [MAX_SYMBOLS-1:0] r_code;
    logic [2:0]             r_sym_cnt;
    logic                   r_err_flag;
    logic                   r_letter_done;

    logic                   r_sym_valid;
    logic                   r_sym_is_dash;
    logic                   r_letter_valid;
    logic [MAX_SYMBOLS-1:0] r_letter_code;
    logic [2:0]             r_letter_len;
    logic                   r_letter_err;
    logic                   r_word_gap;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_tick;
    logic [MS_W-1:0]        w_ms_now;
    logic                   w_dash;
    logic                   w_letter_hit;
    logic                   w_word_hit;

    assign w_rise = r_armed &  btn_in & ~r_btn_d;
    assign w_fall = r_armed & ~btn_in &  r_btn_d;
    assign w_edge = w_rise | w_fall;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_edge),
        .tick  (w_tick)
    );

    // Elapsed ms including the tick completing in this cycle, so a press held
    // for exactly N ms of clocks reads N when its fall is sampled.
    assign w_ms_now = w_tick ? sat_inc(r_ms_cnt) : r_ms_cnt;
    assign w_dash   = (w_ms_now >= MS_W'(DOT_MAX_MS)) ? SYM_DASH : SYM_DOT;

    assign w_letter_hit = (r_state == ST_GAP) && !r_letter_done &&
                          (r_sym_cnt != 3'd0) && (w_ms_now == MS_W'(LETTER_GAP_MS));
    assign w_word_hit   = (r_state == ST_GAP) && (w_ms_now == MS_W'(WORD_GAP_MS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_d  <= 1'b0;
            r_armed  <= 1'b0;
            r_ms_cnt <= '0;
        end else begin
            r_btn_d <= btn_in;
            r_armed <= r_armed | ~btn_in;
            if (w_edge) begin
                r_ms_cnt <= '0;
            end else if (w_tick) begin
                r_ms_cnt <= sat_inc(r_ms_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_code         <= '0;
            r_sym_cnt      <= 3'd0;
            r_err_flag     <= 1'b0;
            r_letter_done  <= 1'b0;
            r_sym_valid    <= 1'b0;
            r_sym_is_dash  <= 1'b0;
            r_letter_valid <= 1'b0;
            r_letter_code  <= '0;
            r_letter_len   <= 3'd0;
            r_letter_err   <= 1'b0;
            r_word_gap     <= 1'b0;
        end else begin
            r_sym_valid    <= 1'b0;
            r_letter_valid <= 1'b0;
            r_word_gap     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_sym_valid   <= 1'b1;
                        r_sym_is_dash <= w_dash;
                        if (r_sym_cnt < 3'(MAX_SYMBOLS)) begin
                            r_code    <= r_code |
                                         ({{(MAX_SYMBOLS-1){1'b0}}, w_dash} << r_sym_cnt);
                            r_sym_cnt <= r_sym_cnt + 3'd1;
                        end else begin
                            r_err_flag <= 1'b1;
                        end
                        r_letter_done <= 1'b0;
                        r_state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // A rise on the threshold cycle still closes the old letter;
                    // the buffer clears here before the new press is classified.
                    if (w_letter_hit) begin
                        r_letter_valid <= 1'b1;
                        r_letter_code  <= r_code;
                        r_letter_len   <= r_sym_cnt;
                        r_letter_err   <= r_err_flag;
                        r_code         <= '0;
                        r_sym_cnt      <= 3'd0;
                        r_err_flag     <= 1'b0;
                        r_letter_done  <= 1'b1;
                    end
                    if (w_word_hit) begin
                        r_word_gap <= 1'b1;
                        r_state    <= w_rise ? ST_PRESSED : ST_IDLE;
                    end else if (w_rise) begin
                        r_state <= ST_PRESSED;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sym_valid    = r_sym_valid;
    assign sym_is_dash  = r_sym_is_dash;
    assign letter_valid = r_letter_valid;
    assign letter_code  = r_letter_code;
    assign letter_len   = r_letter_len;
    assign letter_err   = r_letter_err;
    assign word_gap     = r_word_gap;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_morse_press_classifier.sv
// Directed bench for morse_press_classifier at 2 kHz (1 ms = 2 clocks) with default ms thresholds.
module tb_morse_press_classifier;

    localparam int CLK_FREQ = 2000;
    localparam int MS       = CLK_FREQ / 1000;
    localparam int NSYM     = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            btn_in;
    logic            sym_valid;
    logic            sym_is_dash;
    logic            letter_valid;
    logic [NSYM-1:0] letter_code;
    logic [2:0]      letter_len;
    logic            letter_err;
    logic            word_gap;
    logic            busy;

    always #5 clk = ~clk;

    morse_press_classifier #(
        .CLK_FREQ      (CLK_FREQ),
        .DOT_MAX_MS    (200),
        .LETTER_GAP_MS (600),
        .WORD_GAP_MS   (1400),
        .MAX_SYMBOLS   (NSYM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .sym_valid    (sym_valid),
        .sym_is_dash  (sym_is_dash),
        .letter_valid (letter_valid),
        .letter_code  (letter_code),
        .letter_len   (letter_len),
        .letter_err   (letter_err),
        .word_gap     (word_gap),
        .busy         (busy)
    );

    // Event recorder, sampled 1 time unit after each rising edge.
    logic q_sym [$];
    int   m_letters = 0;
    int   m_words   = 0;
    int   m_code    = 0;
    int   m_len     = 0;
    int   m_err     = 0;
    int   m_wide    = 0;
    logic p_sym = 1'b0, p_let = 1'b0, p_word = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sym_valid) q_sym.push_back(sym_is_dash);
        if (letter_valid) begin
            m_letters = m_letters + 1;
            m_code    = int'(letter_code);
            m_len     = int'(letter_len);
            m_err     = int'(letter_err);
        end
        if (word_gap) m_words = m_words + 1;
        if ((sym_valid && p_sym) || (letter_valid && p_let) || (word_gap && p_word))
            m_wide = m_wide + 1;
        p_sym  = sym_valid;
        p_let  = letter_valid;
        p_word = word_gap;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called right after a falling edge; holds btn for exactly `cycles` rising edges.
    task automatic drive(input logic v, input int cycles);
        btn_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic int all_outs();
        return int'({sym_valid, sym_is_dash, letter_valid, letter_code,
                     letter_len, letter_err, word_gap, busy});
    endfunction

    typedef struct {
        int n;
        int pr [6];
        int gp [6];
        int syms;
        int mask;
        int letters;
        int code;
        int len;
        int err;
        int words;
        int busy;
    } vec_t;

    vec_t vecs [8];
    int   b_sym, b_let, b_word, mask;

    initial begin
        vecs[0] = '{n:1, pr:'{100,0,0,0,0,0}, gp:'{700,0,0,0,0,0},
                    syms:1, mask:0, letters:1, code:0, len:1, err:0, words:0, busy:1};
        vecs[1] = '{n:1, pr:'{300,0,0,0,0,0}, gp:'{700,0,0,0,0,0},
                    syms:1, mask:1, letters:1, code:1, len:1, err:0, words:0, busy:1};
        vecs[2] = '{n:2, pr:'{100,300,0,0,0,0}, gp:'{200,1500,0,0,0,0},
                    syms:2, mask:2, letters:1, code:2, len:2, err:0, words:1, busy:0};
        vecs[3] = '{n:6, pr:'{100,100,100,100,100,100}, gp:'{200,200,200,200,200,700},
                    syms:6, mask:0, letters:1, code:0, len:5, err:1, words:0, busy:1};
        vecs[4] = '{n:2, pr:'{199,200,0,0,0,0}, gp:'{200,1500,0,0,0,0},
                    syms:2, mask:2, letters:1, code:2, len:2, err:0, words:1, busy:0};
        vecs[5] = '{n:5, pr:'{300,100,300,100,300,0}, gp:'{200,200,200,200,1500,0},
                    syms:5, mask:21, letters:1, code:21, len:5, err:0, words:1, busy:0};
        // 599 ms gap keeps the letter open; 600 ms gap lands the rise on the letter threshold.
        vecs[6] = '{n:2, pr:'{100,100,0,0,0,0}, gp:'{599,1500,0,0,0,0},
                    syms:2, mask:0, letters:1, code:0, len:2, err:0, words:1, busy:0};
        vecs[7] = '{n:2, pr:'{100,300,0,0,0,0}, gp:'{600,1500,0,0,0,0},
                    syms:2, mask:2, letters:2, code:1, len:1, err:0, words:1, busy:0};

        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            b_sym  = q_sym.size();
            b_let  = m_letters;
            b_word = m_words;
            for (int j = 0; j < vecs[i].n; j++) begin
                drive(1'b1, vecs[i].pr[j] * MS);
                drive(1'b0, vecs[i].gp[j] * MS);
            end
            mask = 0;
            for (int k = b_sym; k < q_sym.size(); k++)
                mask = mask | (int'(q_sym[k]) << (k - b_sym));
            chk($sformatf("v%0d_syms", i),    q_sym.size() - b_sym, vecs[i].syms);
            chk($sformatf("v%0d_dashes", i),  mask,                 vecs[i].mask);
            chk($sformatf("v%0d_letters", i), m_letters - b_let,    vecs[i].letters);
            chk($sformatf("v%0d_code", i),    m_code,               vecs[i].code);
            chk($sformatf("v%0d_len", i),     m_len,                vecs[i].len);
            chk($sformatf("v%0d_err", i),     m_err,                vecs[i].err);
            chk($sformatf("v%0d_words", i),   m_words - b_word,     vecs[i].words);
            chk($sformatf("v%0d_busy", i),    int'(busy),           vecs[i].busy);
        end

        // Reset for 1 ms in the middle of a 150 ms press, button still held.
        b_sym  = q_sym.size();
        b_let  = m_letters;
        b_word = m_words;
        drive(1'b1, 50 * MS);
        chk("rst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_press_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 99 * MS);
        drive(1'b0, 1500 * MS);
        chk("rst_no_sym",    q_sym.size() - b_sym, 0);
        chk("rst_no_letter", m_letters - b_let,    0);
        chk("rst_no_word",   m_words - b_word,     0);
        chk("rst_idle",      int'(busy),           0);

        b_sym  = q_sym.size();
        b_let  = m_letters;
        b_word = m_words;
        drive(1'b1, 250 * MS);
        drive(1'b0, 1500 * MS);
        chk("post_rst_syms",    q_sym.size() - b_sym, 1);
        chk("post_rst_dash",    (q_sym.size() > b_sym) ? int'(q_sym[b_sym]) : -1, 1);
        chk("post_rst_letters", m_letters - b_let, 1);
        chk("post_rst_code",    m_code, 1);
        chk("post_rst_len",     m_len, 1);
        chk("post_rst_words",   m_words - b_word, 1);

        chk("pulse_width", m_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
